mfda_inlet_dose_sequencer: RTL and testbench

- Drives the fluid inlets of a mixing chip (serpentine delay lines feeding cascaded diffusion mixers) from the electrical side.
- Meters a programmed number of pump strokes into each inlet in fixed order, then runs a flush phase that pushes the mixture through the output serpentine.
- Sits between the host command interface and the per-inlet pump/valve drivers; it is the source end of the inlets that the chip netlist consumes.

---
 rtl/mfda_inlet_dose_sequencer_pkg.sv | 43 ++++
 rtl/mfda_inlet_dose_sequencer_if.sv | 42 ++++
 rtl/mfda_stroke_timer.sv | 63 ++++++
 rtl/mfda_inlet_dose_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_mfda_inlet_dose_sequencer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mfda_inlet_dose_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mfda_ctrl_pkg
// Shared types and helpers for the inlet dose sequencer.
//   state_t        : sequencer FSM encoding
//   DEFAULT_CNT_W  : default width of stroke counts and timers
//   dose_slice()   : extracts one inlet's stroke count from the packed bus
// ---------------------------------------------------------------------------
package mfda_ctrl_pkg;

    localparam int DEFAULT_CNT_W = 16;

    // Upper bounds for dose_slice; the packed dose bus is zero-extended to
    // MAX_BUS_W before slicing so one function serves every parameter set.
    localparam int MAX_CNT_W = 32;
    localparam int MAX_BUS_W = 512;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_DOSE   = 3'd2,
        ST_GAP    = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_FIN    = 3'd5
    } state_t;

    // Returns the cnt_w-bit field of inlet 'inlet' (bits [inlet*cnt_w +: cnt_w]).
    function automatic logic [MAX_CNT_W-1:0] dose_slice(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          inlet,
        input int unsigned          cnt_w
    );
        logic [MAX_BUS_W-1:0] shifted;
        logic [MAX_CNT_W-1:0] mask;
        shifted = bus >> (inlet * cnt_w);
        if (cnt_w >= MAX_CNT_W) begin
            mask = '1;
        end else begin
            mask = ({{(MAX_CNT_W-1){1'b0}}, 1'b1} << cnt_w) - {{(MAX_CNT_W-1){1'b0}}, 1'b1};
        end
        return shifted[MAX_CNT_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/mfda_inlet_dose_sequencer_if.sv
// ---------------------------------------------------------------------------
// mfda_inlet_dose_sequencer_if
// Host command bus and pump/valve driver outputs of the dose sequencer.
//   master : host side (drives the command, observes status and drivers)
//   slave  : sequencer side
// Signals: cmd_valid/cmd_ready handshake, dose_cnt (packed per inlet),
// stroke_period, flush_cycles, abort; pump_step, valve_open, flush_en,
// busy, done, aborted, cur_inlet.
// ---------------------------------------------------------------------------
interface mfda_inlet_dose_sequencer_if
    import mfda_ctrl_pkg::*;
#(
    parameter int NUM_INLETS = 3,
    parameter int CNT_W      = DEFAULT_CNT_W
);
    localparam int CUR_W = (NUM_INLETS > 1) ? $clog2(NUM_INLETS) : 1;

    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [NUM_INLETS*CNT_W-1:0] dose_cnt;
    logic [CNT_W-1:0]            stroke_period;
    logic [CNT_W-1:0]            flush_cycles;
    logic                        abort;
    logic [NUM_INLETS-1:0]       pump_step;
    logic [NUM_INLETS-1:0]       valve_open;
    logic                        flush_en;
    logic                        busy;
    logic                        done;
    logic                        aborted;
    logic [CUR_W-1:0]            cur_inlet;

    modport master (
        output cmd_valid, dose_cnt, stroke_period, flush_cycles, abort,
        input  cmd_ready, pump_step, valve_open, flush_en, busy, done, aborted, cur_inlet
    );

    modport slave (
        input  cmd_valid, dose_cnt, stroke_period, flush_cycles, abort,
        output cmd_ready, pump_step, valve_open, flush_en, busy, done, aborted, cur_inlet
    );

endinterface

// File: rtl/mfda_stroke_timer.sv
// ---------------------------------------------------------------------------
// mfda_stroke_timer
// Stroke timer shared by all inlets (dosing is serial, one inlet at a time).
//   clk, rst     : clock, synchronous active-high reset
//   clr          : drop the current dose (abort)
//   start        : load 'count' strokes and restart the period timer
//   run          : inlet is in its dose phase
//   period       : cycles per stroke (already clamped above hi_len)
//   hi_len       : cycles the step pulse stays high at the start of a stroke
//   count        : strokes to deliver, sampled on start (must be non-zero)
//   step         : pump step request for the current cycle
//   last_stroke  : final cycle of the final stroke
// ---------------------------------------------------------------------------
module mfda_stroke_timer
    import mfda_ctrl_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             start,
    input  logic             run,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] hi_len,
    input  logic [CNT_W-1:0] count,
    output logic             step,
    output logic             last_stroke
);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] timer_r;
    logic [CNT_W-1:0] remaining_r;
    logic             period_end_s;

    assign period_end_s = (timer_r == (period - ONE));
    assign step         = run && (timer_r < hi_len);
    assign last_stroke  = run && period_end_s && (remaining_r == ONE);

    // Period timer and remaining-stroke counter.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            timer_r     <= '0;
            remaining_r <= '0;
        end else if (start) begin
            timer_r     <= '0;
            remaining_r <= count;
        end else if (run) begin
            if (period_end_s) begin
                timer_r     <= '0;
                // remaining is >=1 while running; the guard keeps it from wrapping
                remaining_r <= (remaining_r != '0) ? (remaining_r - ONE) : '0;
            end else begin
                timer_r     <= timer_r + ONE;
                remaining_r <= remaining_r;
            end
        end else begin
            timer_r     <= '0;
            remaining_r <= remaining_r;
        end
    end

endmodule

// File: rtl/mfda_inlet_dose_sequencer.sv
// ---------------------------------------------------------------------------
// mfda_inlet_dose_sequencer
// Meters a programmed number of pump strokes into each inlet in index order,
// then runs the outlet flush pump for a programmed number of cycles.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of mfda_inlet_dose_sequencer_if
//              (command handshake + config in, pump/valve/flush/status out)
// All outputs are registered: each one reflects the state of the previous
// cycle, so the first pump step appears one cycle after DOSE is entered.
// cmd_ready and busy are registered from the next state so that they line
// up with the state register and a second command cannot slip in.
// ---------------------------------------------------------------------------
module mfda_inlet_dose_sequencer
    import mfda_ctrl_pkg::*;
#(
    parameter int NUM_INLETS = 3,
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int STROKE_HI  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    mfda_inlet_dose_sequencer_if.slave    bus
);
    localparam int IDX_W = $clog2(NUM_INLETS + 1);
    localparam int CUR_W = (NUM_INLETS > 1) ? $clog2(NUM_INLETS) : 1;

    localparam logic [IDX_W-1:0] END_IDX    = IDX_W'(NUM_INLETS);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] HI_LEN     = CNT_W'(STROKE_HI);
    localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(STROKE_HI + 1);

    state_t                      state_r;
    state_t                      next_state_s;
    logic [IDX_W-1:0]            idx_r;
    logic [NUM_INLETS*CNT_W-1:0] dose_r;
    logic [CNT_W-1:0]            period_r;
    logic [CNT_W-1:0]            flush_r;
    logic [CNT_W-1:0]            flush_cnt_r;

    logic                        accept_s;
    logic                        abort_s;
    logic                        in_range_s;
    logic                        start_s;
    logic                        step_s;
    logic                        last_stroke_s;
    logic                        flush_last_s;
    logic [CNT_W-1:0]            period_in_s;
    logic [CNT_W-1:0]            cur_cnt_s;
    logic [MAX_BUS_W-1:0]        dose_ext_s;
    logic [NUM_INLETS-1:0]       onehot_s;
    logic [CUR_W-1:0]            cur_idx_s;

    logic                        ready_s, busy_s, flush_s, done_s, aborted_s;
    logic [NUM_INLETS-1:0]       pump_s, valve_s;
    logic [CUR_W-1:0]            cur_s;

    logic                        cmd_ready_r, busy_r, flush_en_r, done_r, aborted_r;
    logic [NUM_INLETS-1:0]       pump_step_r, valve_open_r;
    logic [CUR_W-1:0]            cur_inlet_r;

    assign accept_s     = bus.cmd_valid && cmd_ready_r && (state_r == ST_IDLE);
    assign abort_s      = bus.abort && (state_r != ST_IDLE);
    assign in_range_s   = (idx_r != END_IDX);
    assign period_in_s  = (bus.stroke_period < MIN_PERIOD) ? MIN_PERIOD : bus.stroke_period;
    assign dose_ext_s   = MAX_BUS_W'(dose_r);
    assign cur_cnt_s    = CNT_W'(dose_slice(dose_ext_s, 32'(idx_r), CNT_W));
    assign start_s      = (state_r == ST_SELECT) && in_range_s && (cur_cnt_s != '0);
    // Only reached with flush_r >= 1: a zero flush skips FLUSH entirely.
    assign flush_last_s = (flush_cnt_r == (flush_r - CNT_ONE));
    assign cur_idx_s    = in_range_s ? CUR_W'(idx_r) : '0;

    // One-hot decode of the active inlet index.
    always_comb begin
        onehot_s = '0;
        for (int i = 0; i < NUM_INLETS; i++) begin
            onehot_s[i] = (idx_r == IDX_W'(i));
        end
    end

    mfda_stroke_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .clr         (abort_s),
        .start       (start_s),
        .run         (state_r == ST_DOSE),
        .period      (period_r),
        .hi_len      (HI_LEN),
        .count       (cur_cnt_s),
        .step        (step_s),
        .last_stroke (last_stroke_s)
    );

    // Command configuration latch, captured only on the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            dose_r   <= '0;
            period_r <= '0;
            flush_r  <= '0;
        end else if (accept_s) begin
            dose_r   <= bus.dose_cnt;
            period_r <= period_in_s;
            flush_r  <= bus.flush_cycles;
        end else begin
            dose_r   <= dose_r;
            period_r <= period_r;
            flush_r  <= flush_r;
        end
    end

    // Inlet index and flush-duration counter.
    always_ff @(posedge clk) begin
        if (rst || abort_s) begin
            idx_r       <= '0;
            flush_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_SELECT: begin
                    // A zero-stroke inlet is skipped without opening its valve.
                    if (in_range_s && (cur_cnt_s == '0)) begin
                        idx_r <= idx_r + IDX_ONE;
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                ST_DOSE:  idx_r <= idx_r;
                ST_GAP:   idx_r <= idx_r + IDX_ONE;
                ST_FLUSH: idx_r <= idx_r;
                default:  idx_r <= '0;
            endcase
            if (state_r == ST_FLUSH) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= '0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; abort from any active state returns to IDLE.
    always_comb begin
        next_state_s = state_r;
        if (abort_s) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) next_state_s = ST_SELECT;
                    else          next_state_s = ST_IDLE;
                end
                ST_SELECT: begin
                    if (!in_range_s) begin
                        if (flush_r == '0) next_state_s = ST_FIN;
                        else               next_state_s = ST_FLUSH;
                    end else if (cur_cnt_s == '0) begin
                        next_state_s = ST_SELECT;
                    end else begin
                        next_state_s = ST_DOSE;
                    end
                end
                ST_DOSE: begin
                    if (last_stroke_s) next_state_s = ST_GAP;
                    else               next_state_s = ST_DOSE;
                end
                ST_GAP: next_state_s = ST_SELECT;
                ST_FLUSH: begin
                    if (flush_last_s) next_state_s = ST_FIN;
                    else              next_state_s = ST_FLUSH;
                end
                ST_FIN:  next_state_s = ST_IDLE;
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // FSM output decode; valves and pump only ever drive the single active inlet.
    always_comb begin
        pump_s    = '0;
        valve_s   = '0;
        flush_s   = 1'b0;
        done_s    = 1'b0;
        aborted_s = 1'b0;
        cur_s     = '0;
        busy_s    = (next_state_s != ST_IDLE);
        ready_s   = (next_state_s == ST_IDLE);
        if (abort_s) begin
            aborted_s = 1'b1;
        end else begin
            case (state_r)
                ST_DOSE: begin
                    valve_s = onehot_s;
                    cur_s   = cur_idx_s;
                    if (step_s) pump_s = onehot_s;
                    else        pump_s = '0;
                end
                ST_SELECT, ST_GAP: cur_s = cur_idx_s;
                ST_FLUSH:          flush_s = 1'b1;
                ST_FIN:            done_s = 1'b1;
                default:           cur_s = '0;
            endcase
        end
    end

    // Output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            pump_step_r  <= '0;
            valve_open_r <= '0;
            flush_en_r   <= 1'b0;
            done_r       <= 1'b0;
            aborted_r    <= 1'b0;
            cur_inlet_r  <= '0;
        end else begin
            cmd_ready_r  <= ready_s;
            busy_r       <= busy_s;
            pump_step_r  <= pump_s;
            valve_open_r <= valve_s;
            flush_en_r   <= flush_s;
            done_r       <= done_s;
            aborted_r    <= aborted_s;
            cur_inlet_r  <= cur_s;
        end
    end

    assign bus.cmd_ready  = cmd_ready_r;
    assign bus.busy       = busy_r;
    assign bus.pump_step  = pump_step_r;
    assign bus.valve_open = valve_open_r;
    assign bus.flush_en   = flush_en_r;
    assign bus.done       = done_r;
    assign bus.aborted    = aborted_r;
    assign bus.cur_inlet  = cur_inlet_r;

endmodule

// File: tb/tb_mfda_inlet_dose_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mfda_inlet_dose_sequencer
// Directed testbench for mfda_inlet_dose_sequencer (3 inlets, 16-bit counts,
// 4-cycle stroke pulse). Cycle n counts edges after the accepting edge;
// outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_mfda_inlet_dose_sequencer;

    localparam int NI = 3;
    localparam int CW = 16;
    localparam int SH = 4;

    logic clk = 1'b0;
    logic rst;

    mfda_inlet_dose_sequencer_if #(.NUM_INLETS(NI), .CNT_W(CW)) bus ();

    mfda_inlet_dose_sequencer #(
        .NUM_INLETS (NI),
        .CNT_W      (CW),
        .STROKE_HI  (SH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // statistics gathered by run_to_done
    int st_done_n;
    int st_flush;
    int st_ovl;
    int st_rise[NI];
    int st_hi[NI];
    int st_valve[NI];
    int st_first[NI];
    int st_last[NI];

    // {cmd_ready, busy, done, aborted, flush_en, pump[2:0], valve[2:0], cur[1:0]}
    localparam logic [12:0] IDLE_OUTS  = 13'h1000;
    localparam logic [12:0] ABORT_OUTS = 13'h1200;

    function automatic logic [12:0] outs();
        return {bus.cmd_ready, bus.busy, bus.done, bus.aborted, bus.flush_en,
                bus.pump_step, bus.valve_open, bus.cur_inlet};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_accept(input logic [15:0] c2, input logic [15:0] c1, input logic [15:0] c0,
                             input logic [15:0] per, input logic [15:0] fl, input bit keep);
        bus.dose_cnt      = {c2, c1, c0};
        bus.stroke_period = per;
        bus.flush_cycles  = fl;
        bus.cmd_valid     = 1'b1;
        for (int w = 0; w < 200 && bus.cmd_ready !== 1'b1; w++) tick();
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_wait: cmd_ready=%b required 1", bus.cmd_ready);
        end
        tick();
        if (!keep) bus.cmd_valid = 1'b0;
    endtask

    // Runs until done (or budget), collecting stroke/valve/flush statistics.
    task automatic run_to_done(input int max_cyc);
        logic [NI-1:0] prev;
        prev = bus.pump_step;
        st_done_n = -1; st_flush = 0; st_ovl = 0;
        for (int i = 0; i < NI; i++) begin
            st_rise[i] = 0; st_hi[i] = 0; st_valve[i] = 0; st_first[i] = -1; st_last[i] = -1;
        end
        for (int n = 1; n <= max_cyc; n++) begin
            tick();
            for (int i = 0; i < NI; i++) begin
                if (bus.pump_step[i] && !prev[i]) begin
                    st_rise[i]++;
                    if (st_first[i] < 0) st_first[i] = n;
                    st_last[i] = n;
                end
                if (bus.pump_step[i])  st_hi[i]++;
                if (bus.valve_open[i]) st_valve[i]++;
            end
            if (bus.flush_en) st_flush++;
            if ($countones(bus.pump_step) > 1 || $countones(bus.valve_open) > 1 ||
                (bus.flush_en && (bus.valve_open != '0)) || ((bus.pump_step & ~bus.valve_open) != '0))
                st_ovl++;
            prev = bus.pump_step;
            if (bus.done === 1'b1) begin
                st_done_n = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if (outs() !== IDLE_OUTS) begin
            n_fail++;
            $display("FAIL reset_outs: got %h required %h", outs(), IDLE_OUTS);
        end
        rst = 1'b0;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        n_checks++;
        if (outs() !== IDLE_OUTS) begin
            n_fail++;
            $display("FAIL idle_abort_ignored: got %h required %h", outs(), IDLE_OUTS);
        end
    endtask

    task automatic test_mid_dose_reset();
        do_accept(16'd3, 16'd2, 16'd1, 16'd8, 16'd5, 1'b0);
        for (int n = 1; n <= 21; n++) tick();
        n_checks++;
        if ({bus.pump_step, bus.valve_open} !== 6'b010_010) begin
            n_fail++;
            $display("FAIL mid_dose_state: pump/valve=%b required 010010", {bus.pump_step, bus.valve_open});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (outs() !== IDLE_OUTS) begin
            n_fail++;
            $display("FAIL mid_dose_reset: got %h required %h", outs(), IDLE_OUTS);
        end
        tick();
        n_checks++;
        if (outs() !== IDLE_OUTS) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %h required %h", outs(), IDLE_OUTS);
        end
    endtask

    task automatic test_main_sequence();
        logic [2:0]  ev, ep;
        logic [1:0]  ec;
        logic [12:0] exp_o;
        int          errs;
        errs = 0;
        do_accept(16'd3, 16'd2, 16'd1, 16'd8, 16'd5, 1'b0);
        for (int n = 1; n <= 61; n++) begin
            tick();
            ev = 3'b000; ep = 3'b000;
            if (n >= 2 && n <= 9) begin
                ev = 3'b001; if (((n - 2) % 8) < 4) ep = 3'b001;
            end else if (n >= 12 && n <= 27) begin
                ev = 3'b010; if (((n - 12) % 8) < 4) ep = 3'b010;
            end else if (n >= 30 && n <= 53) begin
                ev = 3'b100; if (((n - 30) % 8) < 4) ep = 3'b100;
            end
            if (n <= 10)      ec = 2'd0;
            else if (n <= 28) ec = 2'd1;
            else if (n <= 54) ec = 2'd2;
            else              ec = 2'd0;
            exp_o = {(n >= 61), (n < 61), (n == 61), 1'b0, (n >= 56 && n <= 60), ep, ev, ec};
            n_checks++;
            if (outs() !== exp_o) begin
                n_fail++;
                errs++;
                if (errs <= 8) $display("FAIL main_seq_cycle%0d: got %h required %h", n, outs(), exp_o);
            end
        end
        tick();
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_single_pulse: done=%b required 0", bus.done);
        end
    endtask

    task automatic test_skip_clamp();
        do_accept(16'd0, 16'd4, 16'd0, 16'd2, 16'd0, 1'b0);
        run_to_done(100);
        n_checks++;
        if (st_done_n != 26) begin
            n_fail++; $display("FAIL clamp_done_cycle: got %0d required 26", st_done_n);
        end
        n_checks++;
        if (st_rise[0] != 0 || st_rise[1] != 4 || st_rise[2] != 0) begin
            n_fail++; $display("FAIL clamp_strokes: got %0d/%0d/%0d required 0/4/0", st_rise[0], st_rise[1], st_rise[2]);
        end
        n_checks++;
        if (st_first[1] != 3 || st_last[1] != 18 || st_hi[1] != 16) begin
            n_fail++; $display("FAIL clamp_spacing: first=%0d last=%0d hi=%0d required 3/18/16", st_first[1], st_last[1], st_hi[1]);
        end
        n_checks++;
        if (st_valve[0] != 0 || st_valve[1] != 20 || st_valve[2] != 0 || st_ovl != 0) begin
            n_fail++; $display("FAIL clamp_valves: got %0d/%0d/%0d ovl=%0d required 0/20/0 ovl=0", st_valve[0], st_valve[1], st_valve[2], st_ovl);
        end
    endtask

    task automatic test_abort();
        do_accept(16'd3, 16'd2, 16'd1, 16'd8, 16'd5, 1'b0);
        for (int n = 1; n <= 47; n++) tick();
        n_checks++;
        if (bus.pump_step !== 3'b100) begin
            n_fail++; $display("FAIL abort_setup: pump=%b required 100", bus.pump_step);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        n_checks++;
        if (outs() !== ABORT_OUTS) begin
            n_fail++; $display("FAIL abort_outs: got %h required %h", outs(), ABORT_OUTS);
        end
        do_accept(16'd0, 16'd0, 16'd0, 16'd5, 16'd2, 1'b0);
        n_checks++;
        if ({bus.busy, bus.aborted, bus.cmd_ready} !== 3'b100) begin
            n_fail++; $display("FAIL abort_reaccept: busy/aborted/ready=%b required 100", {bus.busy, bus.aborted, bus.cmd_ready});
        end
        run_to_done(50);
        n_checks++;
        if (st_done_n != 7 || st_flush != 2) begin
            n_fail++; $display("FAIL flush_only_run: done=%0d flush=%0d required 7/2", st_done_n, st_flush);
        end
    endtask

    task automatic test_hold_valid();
        do_accept(16'd0, 16'd0, 16'd1, 16'd5, 16'd1, 1'b1);
        bus.dose_cnt      = {16'd0, 16'd2, 16'd0};
        bus.stroke_period = 16'd6;
        bus.flush_cycles  = 16'd3;
        run_to_done(100);
        n_checks++;
        if (st_done_n != 12 || st_rise[0] != 1 || st_rise[1] != 0 || st_flush != 1) begin
            n_fail++; $display("FAIL hold_first_run: done=%0d r0=%0d r1=%0d flush=%0d required 12/1/0/1", st_done_n, st_rise[0], st_rise[1], st_flush);
        end
        n_checks++;
        if ({bus.cmd_ready, bus.busy} !== 2'b10) begin
            n_fail++; $display("FAIL hold_ready_at_done: ready/busy=%b required 10", {bus.cmd_ready, bus.busy});
        end
        tick();
        bus.cmd_valid = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL hold_second_accept: busy=%b required 1", bus.busy);
        end
        run_to_done(100);
        n_checks++;
        if (st_done_n != 21 || st_rise[1] != 2 || st_rise[0] != 0 || st_first[1] != 3 || st_flush != 3) begin
            n_fail++; $display("FAIL hold_second_run: done=%0d r1=%0d r0=%0d first=%0d flush=%0d required 21/2/0/3/3",
                               st_done_n, st_rise[1], st_rise[0], st_first[1], st_flush);
        end
    endtask

    task automatic test_all_zero();
        do_accept(16'd0, 16'd0, 16'd0, 16'd8, 16'd0, 1'b0);
        run_to_done(20);
        n_checks++;
        if (st_done_n != 5) begin
            n_fail++; $display("FAIL zero_done_cycle: got %0d required 5", st_done_n);
        end
        n_checks++;
        if (st_flush != 0 || st_valve[0] + st_valve[1] + st_valve[2] != 0 || st_rise[0] + st_rise[1] + st_rise[2] != 0) begin
            n_fail++; $display("FAIL zero_no_activity: flush=%0d valves=%0d strokes=%0d required 0/0/0",
                               st_flush, st_valve[0] + st_valve[1] + st_valve[2], st_rise[0] + st_rise[1] + st_rise[2]);
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus.cmd_valid     = 1'b0;
        bus.abort         = 1'b0;
        bus.dose_cnt      = '0;
        bus.stroke_period = '0;
        bus.flush_cycles  = '0;
        test_reset();
        test_mid_dose_reset();
        test_main_sequence();
        test_skip_clamp();
        test_abort();
        test_hold_valid();
        test_all_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
